// File: rtl/tow_match_scorer_if.sv
`default_nettype none
// ============================================================================
// Module   : tow_match_scorer_if
// Purpose  : Bundles the push-arbiter inputs and the display/score outputs of
//            the tug-of-war match scorer.
// Ports    : master - push arbiter / display side (drives pushes, reads score)
//            slave  - scorer side (reads pushes, drives score and match state)
// Revision : 1.0 - initial release
// ============================================================================
interface tow_match_scorer_if #(
  parameter int STEPS = 3,
  parameter int CNT_W = 4
);
  logic               winrnd;
  logic               right;
  logic               leds_on;
  logic               rnd_clr;
  logic [2*STEPS:0]   hcap_in;
  logic [2*STEPS:0]   score;
  logic               round_done;
  logic [CNT_W-1:0]   wins_l;
  logic [CNT_W-1:0]   wins_r;
  logic               match_win_l;
  logic               match_win_r;

  modport master (
    output winrnd, right, leds_on, rnd_clr, hcap_in,
    input  score, round_done, wins_l, wins_r, match_win_l, match_win_r
  );

  modport slave (
    input  winrnd, right, leds_on, rnd_clr, hcap_in,
    output score, round_done, wins_l, wins_r, match_win_l, match_win_r
  );
endinterface
`default_nettype wire

// File: rtl/tow_match_scorer.sv
`default_nettype none
// ============================================================================
// Module   : tow_match_scorer
// Purpose  : Tug-of-war rope position tracker with jump-the-light penalties,
//            per-position double-step handicaps and a best-of match layer.
// Ports    : clk  - system clock
//            rst  - asynchronous active-high reset
//            bus  - tow_match_scorer_if.slave (winrnd/right/leds_on/rnd_clr/
//                   hcap_in in; score/round_done/wins_*/match_win_* out)
// Revision : 1.0 - initial release
// ============================================================================
module tow_match_scorer #(
  parameter int STEPS      = 3,
  parameter int WIN_ROUNDS = 2,
  parameter int CNT_W      = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  tow_match_scorer_if.slave   bus
);

  localparam int SW = 2*STEPS + 1;         // score width
  localparam int PW = $clog2(2*STEPS + 3); // position index width

  localparam logic [PW-1:0] C_POS_WR = '0;
  localparam logic [PW-1:0] C_POS_N  = PW'(STEPS + 1);
  localparam logic [PW-1:0] C_POS_WL = PW'(2*STEPS + 2);

  localparam logic [1:0] S_PLAY = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Error pattern 1010... starting with a 1 in the MSB.
  function automatic logic [SW-1:0] alt_pattern();
    logic [SW-1:0] p;
    for (int k = 0; k < SW; k++) p[k] = ((SW - 1 - k) % 2) == 0;
    return p;
  endfunction

  localparam logic [SW-1:0] C_ERR = alt_pattern();

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [SW-1:0]    hcap_q, hcap_d;
  logic [CNT_W-1:0] wins_l_q, wins_l_d, wins_r_q, wins_r_d;
  logic             round_done_q, round_done_d;
  logic             match_l_q, match_l_d, match_r_q, match_r_d;

  logic             mr;
  logic             hbit;
  logic             toward;
  logic [PW:0]      step;
  logic [PW:0]      ext;
  logic [PW:0]      moved;
  logic [PW-1:0]    pushed_pos;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_PLAY;
      pos_q        <= C_POS_N;
      hcap_q       <= '0;
      wins_l_q     <= '0;
      wins_r_q     <= '0;
      round_done_q <= 1'b0;
      match_l_q    <= 1'b0;
      match_r_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      hcap_q       <= hcap_d;
      wins_l_q     <= wins_l_d;
      wins_r_q     <= wins_r_d;
      round_done_q <= round_done_d;
      match_l_q    <= match_l_d;
      match_r_q    <= match_r_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // A push counts toward the right when the right player pushed on the
    // lights, or the left player jumped the light.
    mr = bus.right ? bus.leds_on : ~bus.leds_on;

    hbit = 1'b0;
    for (int k = 0; k < SW; k++) begin
      if (pos_q == PW'(k + 1)) hbit = hcap_q[k];
    end

    // Left of neutral is a higher index; excludes N itself on both sides.
    toward = ((pos_q > C_POS_N) && mr) || ((pos_q < C_POS_N) && !mr);
    step   = (bus.leds_on && hbit && toward) ? (PW+1)'(2) : (PW+1)'(1);
    ext    = {1'b0, pos_q};

    if (mr) moved = (ext < step) ? '0 : ext - step;
    else    moved = (ext + step > {1'b0, C_POS_WL}) ? {1'b0, C_POS_WL} : ext + step;
    pushed_pos = moved[PW-1:0];

    state_d      = state_q;
    pos_d        = pos_q;
    wins_l_d     = wins_l_q;
    wins_r_d     = wins_r_q;
    round_done_d = 1'b0;
    match_l_d    = match_l_q;
    match_r_d    = match_r_q;
    hcap_d       = (state_q == S_PLAY && pos_q == C_POS_N) ? bus.hcap_in : hcap_q;

    if (pos_q > C_POS_WL) begin
      // Corrupted position: recover to neutral.
      pos_d = C_POS_N;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (bus.rnd_clr) begin
            pos_d = C_POS_N;
          end else if (bus.winrnd) begin
            pos_d = pushed_pos;
            if (pushed_pos == C_POS_WL) begin
              state_d      = S_HOLD;
              wins_l_d     = wins_l_q + 1'b1;
              round_done_d = 1'b1;
            end else if (pushed_pos == C_POS_WR) begin
              state_d      = S_HOLD;
              wins_r_d     = wins_r_q + 1'b1;
              round_done_d = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (bus.rnd_clr) begin
            if (pos_q == C_POS_WL && wins_l_q == CNT_W'(WIN_ROUNDS)) begin
              state_d   = S_DONE;
              match_l_d = 1'b1;
            end else if (pos_q == C_POS_WR && wins_r_q == CNT_W'(WIN_ROUNDS)) begin
              state_d   = S_DONE;
              match_r_d = 1'b1;
            end else begin
              state_d = S_PLAY;
              pos_d   = C_POS_N;
            end
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_PLAY;
          pos_d   = C_POS_N;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    bus.score = '0;
    if (pos_q == C_POS_WL) begin
      bus.score = {{STEPS{1'b1}}, {(STEPS+1){1'b0}}};
    end else if (pos_q == C_POS_WR) begin
      bus.score = {{(STEPS+1){1'b0}}, {STEPS{1'b1}}};
    end else if (pos_q > C_POS_WL) begin
      bus.score = C_ERR;
    end else begin
      for (int k = 0; k < SW; k++) begin
        if (pos_q == PW'(k + 1)) bus.score[k] = 1'b1;
      end
    end
    bus.round_done  = round_done_q;
    bus.wins_l      = wins_l_q;
    bus.wins_r      = wins_r_q;
    bus.match_win_l = match_l_q;
    bus.match_win_r = match_r_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_tow_match_scorer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tow_match_scorer
// Purpose  : Scoreboard bench for tow_match_scorer (STEPS=3, WIN_ROUNDS=2).
//            The driver queues the expected post-edge outputs of each cycle;
//            a monitor pops and compares them on the following falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tow_match_scorer;

  typedef struct {
    int         id;
    logic [6:0] score;
    logic [3:0] wl;
    logic [3:0] wr;
    logic       rd;
    logic       ml;
    logic       mr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc_id = 0;
  exp_t sb[$];

  tow_match_scorer_if #(.STEPS(3), .CNT_W(4)) bus ();

  tow_match_scorer #(.STEPS(3), .WIN_ROUNDS(2), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Monitor: one comparison per queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      if (bus.score !== e.score || bus.wins_l !== e.wl || bus.wins_r !== e.wr ||
          bus.round_done !== e.rd || bus.match_win_l !== e.ml || bus.match_win_r !== e.mr) begin
        fails++;
        $display("FAIL step%0d: got score=%b wl=%0d wr=%0d rd=%b ml=%b mr=%b, want score=%b wl=%0d wr=%0d rd=%b ml=%b mr=%b",
                 e.id, bus.score, bus.wins_l, bus.wins_r, bus.round_done, bus.match_win_l,
                 bus.match_win_r, e.score, e.wl, e.wr, e.rd, e.ml, e.mr);
      end
    end
  end

  // One clock of stimulus; w/c are single-cycle pulses.
  task automatic cyc(input logic w, input logic r, input logic l, input logic c,
                     input logic [6:0] sc, input logic [3:0] wl, input logic [3:0] wr,
                     input logic rd, input logic ml, input logic mr);
    exp_t e;
    @(negedge clk);
    #1;
    bus.winrnd  = w;
    bus.right   = r;
    bus.leds_on = l;
    bus.rnd_clr = c;
    @(posedge clk);
    #1;
    bus.winrnd  = 1'b0;
    bus.rnd_clr = 1'b0;
    cyc_id++;
    e.id = cyc_id; e.score = sc; e.wl = wl; e.wr = wr; e.rd = rd; e.ml = ml; e.mr = mr;
    sb.push_back(e);
  endtask

  initial begin
    bus.winrnd  = 1'b0;
    bus.right   = 1'b0;
    bus.leds_on = 1'b0;
    bus.rnd_clr = 1'b0;
    bus.hcap_in = 7'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Move away from neutral, then reset asynchronously mid-cycle.
    cyc(1, 1, 1, 0, 7'b0000100, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 7'b0000010, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (bus.score !== 7'b0001000 || bus.wins_l !== 4'd0 || bus.wins_r !== 4'd0 ||
        bus.match_win_l !== 1'b0 || bus.match_win_r !== 1'b0 || bus.round_done !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got score=%b wl=%0d wr=%0d rd=%b ml=%b mr=%b, want 0001000 0 0 0 0 0",
               bus.score, bus.wins_l, bus.wins_r, bus.round_done, bus.match_win_l, bus.match_win_r);
    end
    @(negedge clk);
    #1 rst = 1'b0;

    // Right wins a round with proper pushes, no handicap.
    cyc(0, 0, 0, 0, 7'b0001000, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 7'b0000100, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 7'b0000010, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 7'b0000001, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 7'b0000111, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 7'b0000111, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 7'b0000111, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 7'b0001000, 0, 1, 0, 0, 0);

    // Jump-the-light: always a single step, handicap or not.
    cyc(1, 1, 0, 0, 7'b0010000, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 7'b0001000, 0, 1, 0, 0, 0);
    bus.hcap_in = 7'h7F;
    cyc(0, 0, 0, 0, 7'b0001000, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 7'b0010000, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 7'b0100000, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 7'b0010000, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 7'b0001000, 0, 1, 0, 0, 0);

    // Handicap on L2: double step back toward neutral, none from N.
    bus.hcap_in = 7'b0100000;
    cyc(0, 0, 0, 0, 7'b0001000, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 7'b0010000, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 7'b0100000, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 7'b0001000, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 7'b0000100, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 7'b0001000, 0, 1, 0, 0, 0);

    // rnd_clr beats a simultaneous push.
    cyc(1, 1, 1, 0, 7'b0000100, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 7'b0000010, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 7'b0001000, 0, 1, 0, 0, 0);

    // Left wins a round; one win is short of the match.
    cyc(1, 0, 1, 0, 7'b0010000, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 7'b0100000, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 7'b1000000, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 7'b1110000, 1, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 7'b0001000, 1, 1, 0, 0, 0);

    // Right takes the match; everything after is ignored.
    cyc(1, 1, 1, 0, 7'b0000100, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 7'b0000010, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 7'b0000001, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 7'b0000111, 1, 2, 1, 0, 0);
    cyc(0, 0, 0, 1, 7'b0000111, 1, 2, 0, 0, 1);
    cyc(1, 0, 1, 0, 7'b0000111, 1, 2, 0, 0, 1);
    cyc(0, 0, 0, 1, 7'b0000111, 1, 2, 0, 0, 1);
    cyc(1, 1, 0, 1, 7'b0000111, 1, 2, 0, 0, 1);
    cyc(0, 0, 0, 0, 7'b0000111, 1, 2, 0, 0, 1);

    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
